interp_sequencer: RTL and testbench
===================================

# interp_sequencer

Sequences the interpolating FIR so that each input sample yields L filter updates: one carrying the sample, L-1 carrying zeros (zero-stuffing upsampler). It sits between the sample source (`entrada`/`amostra_pronta`) and the FIR's `enable`/`entrada` inputs, so the FIR and the downstream zero-crossing detector run at L times the input rate. A one-deep pending buffer absorbs a sample that arrives mid-frame. Overrun is flagged and counted.

## Interface
- `L`, 4: interpolation factor, number of FIR enables per input sample; legal range ≥ 2.
- `SPACING`, 8: clocks between consecutive FIR enables within a frame; legal range ≥ 1.
- `W_IN`, 32: sample width; the top level zero-pads the FIR input.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `amostra_pronta` in 1: one-cycle strobe; `entrada` is valid in the same cycle.
- `entrada` in W_IN: signed input sample.
- `fir_enable` out 1: one-cycle enable to the FIR.
- `fir_entrada` out W_IN: FIR input. Equals the sample on phase 0 and 0 on phases 1..L-1; 0 whenever `fir_enable`=0.
- `phase` out clog2(L): index of the current/last emission, 0..L-1.
- `busy` out 1: high from the first emission of a frame through its last emission, inclusive.
- `overrun` out 1: one-cycle pulse when a sample is dropped.
- `drop_cnt` out 8: count of dropped samples; saturates at 255.

## Operation
- All outputs are registered. On reset, every output is 0, FSM = IDLE, pending buffer is empty, and the gap counter is 0.
- FSM states:
  - IDLE: no frame active.
  - EMIT: `fir_enable` high for this cycle.
  - GAP: waiting SPACING-1 cycles before the next emission.
- IDLE:
  - If pending is valid: launch using the pending sample and clear pending.
  - Else if `amostra_pronta`: launch using `entrada`.
  - Launch means: go to EMIT with phase 0, and latch the sample into the frame register.
- EMIT:
  - `fir_enable`=1. `fir_entrada` = frame sample if phase=0, else 0.
  - If phase=L-1, go to IDLE.
  - Else if SPACING=1, stay in EMIT with phase+1.
  - Else go to GAP with gap counter = SPACING-1.
- GAP: decrement the counter. When the counter reaches 1, next state = EMIT with phase+1.
- Sample arrival when not launching directly:
  - An `amostra_pronta` outside IDLE, or in IDLE while pending is valid, is written into pending if pending is empty.
  - If pending is full, the new sample is dropped: `overrun` pulses next cycle and `drop_cnt` increments (saturating).
- Simultaneous events:
  - In IDLE with pending valid and `amostra_pronta`: the pending sample launches and the new sample refills pending. No drop occurs.
  - `amostra_pronta` on the final EMIT cycle goes to pending (if empty). It launches from the following IDLE cycle.
- `phase` holds its last value between frames. Reset clears it to 0.
- `drop_cnt` is cleared only by reset.

## Timing
- Fresh sample accepted in IDLE at cycle t: emissions at t+1, t+1+SPACING, ..., t+1+(L-1)·SPACING.
- `busy` is high over [t+1, t+1+(L-1)·SPACING].
- Frame length is (L-1)·SPACING+1 cycles. The next launch decision is made in the IDLE cycle after the last emission, and that emission follows one cycle later.
- Maximum sustained input rate without drops: one sample per (L-1)·SPACING+2 cycles. One extra sample per frame is absorbed by pending.
- `overrun` and the `drop_cnt` update both occur at t+1 for a drop at cycle t.
- Reset mid-frame takes effect immediately:
  - `fir_enable`, `busy`, and `fir_entrada` drop to 0.
  - Pending is discarded.
  - No partial frame resumes after release; the first `amostra_pronta` accepted after reset starts a new frame.

## Test plan
- Single sample, L=4, SPACING=8: `entrada`=0x00001234 strobed at cycle 10.
  - `fir_enable` is high at cycles 11, 19, 27, 35.
  - `fir_entrada` = 0x1234, 0, 0, 0; `phase` = 0, 1, 2, 3.
  - `busy` is high 11..35 and low at 36.
- Pending buffer: sample A at cycle 10, sample B at cycle 20.
  - A's frame emits at 11..35. B emits phase 0 at cycle 37 with `fir_entrada`=B, then 45, 53, 61.
  - `overrun` stays 0.
- Overrun: samples at cycles 10, 20, 25.
  - The sample at 25 is dropped: `overrun` pulses at cycle 26 and `drop_cnt`=1.
  - The sample at 20 is emitted starting at cycle 37.
- Saturation: drive 300 drops → `drop_cnt` stops at 255; `overrun` still pulses on every drop.
- SPACING=1, L=4, negative sample 0xFFFF8000 at cycle 5:
  - `fir_enable` is high at 6, 7, 8, 9.
  - `fir_entrada` = 0xFFFF8000, 0, 0, 0.
- Reset mid-frame: assert `reset` at cycle 20 of a frame started at 10, with pending full.
  - All outputs are 0 at 20, with no further enables.
  - A strobe 3 cycles after release starts a fresh frame with phase 0.

Source files
------------

// File: rtl/interp_sequencer_if.sv
// Purpose: sample-in / FIR-feed bundle for interp_sequencer.
// Signals:
//   amostra_pronta  one-cycle strobe, entrada valid in the same cycle
//   entrada         signed input sample (W_IN bits)
//   fir_enable      one-cycle FIR update enable
//   fir_entrada     FIR input: sample on phase 0, zero otherwise
//   phase           index of the current/last emission (0..L-1)
//   busy            frame in progress, first through last emission
//   overrun         one-cycle pulse when a sample is dropped
//   drop_cnt        saturating count of dropped samples
// Modports: master = sample source / FIR side, slave = sequencer.
interface interp_sequencer_if #(
    parameter int unsigned L    = 4,
    parameter int unsigned W_IN = 32
);
    localparam int unsigned PHASE_W = (L > 1) ? $clog2(L) : 1;

    logic               amostra_pronta;
    logic [W_IN-1:0]    entrada;
    logic               fir_enable;
    logic [W_IN-1:0]    fir_entrada;
    logic [PHASE_W-1:0] phase;
    logic               busy;
    logic               overrun;
    logic [7:0]         drop_cnt;

    modport master (
        output amostra_pronta, entrada,
        input  fir_enable, fir_entrada, phase, busy, overrun, drop_cnt
    );

    modport slave (
        input  amostra_pronta, entrada,
        output fir_enable, fir_entrada, phase, busy, overrun, drop_cnt
    );
endinterface

// File: rtl/interp_sequencer.sv
// Purpose: zero-stuffing upsampler sequencer. Each input sample produces L
// FIR enables spaced SPACING clocks apart: the first carries the sample, the
// rest carry zero. A one-deep pending buffer holds a sample that arrives
// mid-frame; further arrivals while it is full are dropped and counted.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state and outputs
//   bus    interp_sequencer_if.slave (sample in, FIR feed and status out)
module interp_sequencer #(
    parameter int unsigned L       = 4,
    parameter int unsigned SPACING = 8,
    parameter int unsigned W_IN    = 32
) (
    input  logic              clk,
    input  logic              reset,
    interp_sequencer_if.slave bus
);
    localparam int unsigned PHASE_W = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned CNT_W   = (SPACING > 1) ? $clog2(SPACING) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   gap_cnt;
    logic [PHASE_W-1:0] phase_q;
    logic               pend_valid;
    logic [W_IN-1:0]    pend_data;
    logic               fir_enable_q;
    logic [W_IN-1:0]    fir_entrada_q;
    logic               busy_q;
    logic               overrun_q;
    logic [7:0]         drop_cnt_q;

    logic launch_pend_c;
    logic launch_new_c;
    logic store_c;
    logic drop_c;

    // Arrival steering: launch directly, park in pending, or drop.
    always_comb begin
        launch_pend_c = 1'b0;
        launch_new_c  = 1'b0;
        store_c       = 1'b0;
        drop_c        = 1'b0;
        if (state == IDLE) begin
            launch_pend_c = pend_valid;
            launch_new_c  = !pend_valid && bus.amostra_pronta;
        end
        if (bus.amostra_pronta && !launch_new_c) begin
            // Pending is free if empty or being emptied by this launch.
            if (!pend_valid || launch_pend_c) begin
                store_c = 1'b1;
            end else begin
                drop_c = 1'b1;
            end
        end
    end

    // Frame FSM with registered outputs; the phase-0 output register also
    // serves as the frame sample, since only phase 0 carries it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            phase_q       <= '0;
            pend_valid    <= 1'b0;
            pend_data     <= '0;
            fir_enable_q  <= 1'b0;
            fir_entrada_q <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            fir_enable_q  <= 1'b0;
            fir_entrada_q <= '0;
            overrun_q     <= drop_c;

            if (drop_c && drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end

            if (store_c) begin
                pend_valid <= 1'b1;
                pend_data  <= bus.entrada;
            end else if (launch_pend_c) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (launch_pend_c || launch_new_c) begin
                        state         <= EMIT;
                        phase_q       <= '0;
                        fir_enable_q  <= 1'b1;
                        fir_entrada_q <= launch_pend_c ? pend_data : bus.entrada;
                        busy_q        <= 1'b1;
                    end
                end
                EMIT: begin
                    if (phase_q == PHASE_W'(L - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (SPACING == 1) begin
                        state        <= EMIT;
                        phase_q      <= phase_q + PHASE_W'(1);
                        fir_enable_q <= 1'b1;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= CNT_W'(SPACING - 1);
                    end
                end
                GAP: begin
                    if (gap_cnt == CNT_W'(1)) begin
                        state        <= EMIT;
                        phase_q      <= phase_q + PHASE_W'(1);
                        fir_enable_q <= 1'b1;
                    end
                    gap_cnt <= gap_cnt - CNT_W'(1);
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fir_enable  = fir_enable_q;
    assign bus.fir_entrada = fir_entrada_q;
    assign bus.phase       = phase_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_interp_sequencer.sv
// Purpose: directed self-checking bench for interp_sequencer. Two instances
// share stimulus: dut_a (L=4, SPACING=8) and dut_b (L=4, SPACING=1).
// Cycle c is the clock period that begins at the c-th rising edge after
// reset release; inputs are driven and outputs sampled 1 time unit into it.
module tb_interp_sequencer;
    localparam int unsigned L      = 4;
    localparam int unsigned W      = 32;
    // Continuous strobing with SPACING=8: frame launches every 26 cycles.
    localparam int          PERIOD = 26;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    interp_sequencer_if #(.L(L), .W_IN(W)) if_a ();
    interp_sequencer_if #(.L(L), .W_IN(W)) if_b ();

    interp_sequencer #(.L(L), .SPACING(8), .W_IN(W)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    interp_sequencer #(.L(L), .SPACING(1), .W_IN(W)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    typedef struct {
        int         cyc;
        logic [31:0] dat;
        logic [1:0]  ph;
    } emit_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    emit_t got_a[$];
    emit_t got_b[$];
    emit_t want_e[$];
    int    ov_a[$];
    int    busy_first_a, busy_last_a, busy_first_b, busy_last_b;
    int    nz_a, nz_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic bit drop_pat(input int c);
        return (c >= 2) && ((c % PERIOD) != 0);
    endfunction

    task automatic drive(input logic s, input logic [31:0] d);
        if_a.amostra_pronta = s;
        if_a.entrada        = d;
        if_b.amostra_pronta = s;
        if_b.entrada        = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic want(input int c, input logic [31:0] d, input logic [1:0] p);
        emit_t e;
        e.cyc = c;
        e.dat = d;
        e.ph  = p;
        want_e.push_back(e);
    endtask

    task automatic check_emits(input string tag, input bit use_b);
        emit_t e;
        int    n;
        n = use_b ? got_b.size() : got_a.size();
        chk($sformatf("%s_count", tag), 64'(n), 64'(want_e.size()));
        for (int i = 0; i < n && i < want_e.size(); i++) begin
            e = use_b ? got_b[i] : got_a[i];
            chk($sformatf("%s_cyc%0d", tag, i), 64'(e.cyc), 64'(want_e[i].cyc));
            chk($sformatf("%s_dat%0d", tag, i), 64'(e.dat), 64'(want_e[i].dat));
            chk($sformatf("%s_ph%0d", tag, i), 64'(e.ph), 64'(want_e[i].ph));
        end
        want_e.delete();
    endtask

    // Runs one scenario from a fresh reset. Up to three strobes at s0..s2,
    // optional reset at rst_c (held two cycles), or continuous strobing for
    // sat_n cycles with per-cycle overrun / drop_cnt checks.
    task automatic run(input int ncyc, input int s0, input int s1, input int s2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input int rst_c, input int sat_n);
        int    drops;
        emit_t e;
        drops = 0;
        got_a.delete();
        got_b.delete();
        ov_a.delete();
        busy_first_a = -1; busy_last_a = -1;
        busy_first_b = -1; busy_last_b = -1;
        nz_a = 0; nz_b = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (if_a.fir_enable) begin
                e.cyc = c; e.dat = if_a.fir_entrada; e.ph = if_a.phase;
                got_a.push_back(e);
            end else if (if_a.fir_entrada != '0) begin
                nz_a++;
            end
            if (if_b.fir_enable) begin
                e.cyc = c; e.dat = if_b.fir_entrada; e.ph = if_b.phase;
                got_b.push_back(e);
            end else if (if_b.fir_entrada != '0) begin
                nz_b++;
            end
            if (if_a.busy) begin
                if (busy_first_a < 0) busy_first_a = c;
                busy_last_a = c;
            end
            if (if_b.busy) begin
                if (busy_first_b < 0) busy_first_b = c;
                busy_last_b = c;
            end
            if (if_a.overrun) ov_a.push_back(c);

            if (sat_n > 0 && c > 0) begin
                chk($sformatf("sat_overrun_c%0d", c), 64'(if_a.overrun),
                    64'((c - 1 < sat_n) && drop_pat(c - 1)));
                chk($sformatf("sat_drop_cnt_c%0d", c), 64'(if_a.drop_cnt),
                    64'((drops > 255) ? 255 : drops));
            end
            if (c < sat_n && drop_pat(c)) drops++;

            if (c < sat_n)      drive(1'b1, 32'(c));
            else if (c == s0)   drive(1'b1, d0);
            else if (c == s1)   drive(1'b1, d1);
            else if (c == s2)   drive(1'b1, d2);
            else                drive(1'b0, 32'h0);

            if (c == rst_c) begin
                reset = 1'b1;
                #1;
                chk("rst_fir_enable", 64'(if_a.fir_enable), 64'(0));
                chk("rst_fir_entrada", 64'(if_a.fir_entrada), 64'(0));
                chk("rst_busy", 64'(if_a.busy), 64'(0));
                chk("rst_phase", 64'(if_a.phase), 64'(0));
                chk("rst_overrun", 64'(if_a.overrun), 64'(0));
                chk("rst_drop_cnt", 64'(if_a.drop_cnt), 64'(0));
            end
            if (c == rst_c + 2) reset = 1'b0;

            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("init_fir_enable", 64'(if_a.fir_enable), 64'(0));
        chk("init_fir_entrada", 64'(if_a.fir_entrada), 64'(0));
        chk("init_phase", 64'(if_a.phase), 64'(0));
        chk("init_busy", 64'(if_a.busy), 64'(0));
        chk("init_overrun", 64'(if_a.overrun), 64'(0));
        chk("init_drop_cnt", 64'(if_a.drop_cnt), 64'(0));

        // Single sample at cycle 10
        run(45, 10, -1, -1, 32'h0000_1234, 32'h0, 32'h0, -1, 0);
        want(11, 32'h0000_1234, 2'd0);
        want(19, 32'h0, 2'd1);
        want(27, 32'h0, 2'd2);
        want(35, 32'h0, 2'd3);
        check_emits("single", 1'b0);
        chk("single_busy_first", 64'(busy_first_a), 64'(11));
        chk("single_busy_last", 64'(busy_last_a), 64'(35));
        chk("single_zero_fill", 64'(nz_a), 64'(0));
        chk("single_phase_hold", 64'(if_a.phase), 64'(3));
        chk("single_no_overrun", 64'(ov_a.size()), 64'(0));

        // Pending buffer: second sample mid-frame
        run(70, 10, 20, -1, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0, -1, 0);
        want(11, 32'hAAAA_0001, 2'd0);
        want(19, 32'h0, 2'd1);
        want(27, 32'h0, 2'd2);
        want(35, 32'h0, 2'd3);
        want(37, 32'hBBBB_0002, 2'd0);
        want(45, 32'h0, 2'd1);
        want(53, 32'h0, 2'd2);
        want(61, 32'h0, 2'd3);
        check_emits("pend", 1'b0);
        chk("pend_no_overrun", 64'(ov_a.size()), 64'(0));
        chk("pend_drop_cnt", 64'(if_a.drop_cnt), 64'(0));

        // Overrun: third sample dropped
        run(70, 10, 20, 25, 32'h0000_0111, 32'h0000_0222, 32'h0000_0333, -1, 0);
        want(11, 32'h0000_0111, 2'd0);
        want(19, 32'h0, 2'd1);
        want(27, 32'h0, 2'd2);
        want(35, 32'h0, 2'd3);
        want(37, 32'h0000_0222, 2'd0);
        want(45, 32'h0, 2'd1);
        want(53, 32'h0, 2'd2);
        want(61, 32'h0, 2'd3);
        check_emits("ovr", 1'b0);
        chk("ovr_pulses", 64'(ov_a.size()), 64'(1));
        if (ov_a.size() > 0) chk("ovr_cycle", 64'(ov_a[0]), 64'(26));
        chk("ovr_drop_cnt", 64'(if_a.drop_cnt), 64'(1));

        // Saturation: continuous strobing, well over 255 drops
        run(340, -1, -1, -1, 32'h0, 32'h0, 32'h0, -1, 330);
        chk("sat_final", 64'(if_a.drop_cnt), 64'(255));

        // SPACING=1 with a negative sample
        run(20, 5, -1, -1, 32'hFFFF_8000, 32'h0, 32'h0, -1, 0);
        want(6, 32'hFFFF_8000, 2'd0);
        want(7, 32'h0, 2'd1);
        want(8, 32'h0, 2'd2);
        want(9, 32'h0, 2'd3);
        check_emits("sp1", 1'b1);
        chk("sp1_busy_first", 64'(busy_first_b), 64'(6));
        chk("sp1_busy_last", 64'(busy_last_b), 64'(9));
        chk("sp1_zero_fill", 64'(nz_b), 64'(0));

        // Reset mid-frame with pending full; fresh strobe 3 cycles after release
        run(60, 10, 12, 25, 32'h0000_C0DE, 32'h0000_0BAD, 32'h0000_5EED, 20, 0);
        want(11, 32'h0000_C0DE, 2'd0);
        want(19, 32'h0, 2'd1);
        want(26, 32'h0000_5EED, 2'd0);
        want(34, 32'h0, 2'd1);
        want(42, 32'h0, 2'd2);
        want(50, 32'h0, 2'd3);
        check_emits("rst", 1'b0);
        chk("rst_no_overrun", 64'(ov_a.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
